// File: rtl/uart_frame_sequencer.sv
// Sequences one UART/IrDA transmit frame (start, data, optional parity, stop bits)
// from an oversampled baud tick, with abort, back-to-back frames and start-overrun.
module uart_frame_sequencer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
    input  logic             abort,
    output logic             shift,
    output logic             bits_done,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_index,
    output logic [2:0]       field
);

    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int unsigned TICK_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] F_IDLE   = 3'd0;
    localparam logic [2:0] F_START  = 3'd1;
    localparam logic [2:0] F_DATA   = 3'd2;
    localparam logic [2:0] F_PARITY = 3'd3;
    localparam logic [2:0] F_STOP   = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_frame_sequencer: DATA_BITS must be 5..9");
    end
    if (PARITY_EN > 1) begin : g_bad_parity_en
        $error("uart_frame_sequencer: PARITY_EN must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_frame_sequencer: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 1) begin : g_bad_oversample
        $error("uart_frame_sequencer: OVERSAMPLE must be at least 1");
    end
    if ((FRAME_BITS >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("uart_frame_sequencer: CNT_W too narrow for FRAME_BITS");
    end

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic [CNT_W-1:0]  bit_index_d;
    logic              shift_d;
    logic              bits_done_d;
    logic              busy_d;
    logic              overrun_d;
    logic [2:0]        field_d;

    // Map a bit slot to the frame field it carries
    function automatic logic [2:0] field_of(input logic [CNT_W-1:0] idx);
        if (idx == '0) return F_START;
        if (idx <= CNT_W'(DATA_BITS)) return F_DATA;
        if (PARITY_EN != 0 && idx == CNT_W'(DATA_BITS + 1)) return F_PARITY;
        return F_STOP;
    endfunction

    // Next state, counters and next registered outputs
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_index_d = bit_index;
        shift_d     = 1'b0;
        bits_done_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_RUN;
                    tick_cnt_d  = '0;
                    bit_index_d = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    tick_cnt_d  = '0;
                    bit_index_d = '0;
                end else begin
                    overrun_d = start;
                    if (tick) begin
                        if (tick_cnt_q == LAST_TICK) begin
                            tick_cnt_d = '0;
                            shift_d    = 1'b1;
                            if (bit_index == LAST_BIT) begin
                                state_d     = ST_DONE;
                                bits_done_d = 1'b1;
                            end else begin
                                bit_index_d = bit_index + CNT_W'(1);
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                // A start here chains the next frame with no idle gap
                state_d     = (start && !abort) ? ST_RUN : ST_IDLE;
                tick_cnt_d  = '0;
                bit_index_d = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                tick_cnt_d  = '0;
                bit_index_d = '0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        field_d = busy_d ? field_of(bit_index_d) : F_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_index  <= '0;
            shift      <= 1'b0;
            bits_done  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            field      <= F_IDLE;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_index  <= bit_index_d;
            shift      <= shift_d;
            bits_done  <= bits_done_d;
            busy       <= busy_d;
            overrun    <= overrun_d;
            field      <= field_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: default instance plus a 7N2/OVERSAMPLE=4 instance,
// both compared every cycle against a tick-count reference model.
module tb_uart_frame_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic tick0 = 1'b0;
    logic tick1 = 1'b0;

    logic       shift0, bits_done0, busy0, overrun0;
    logic [3:0] bit_index0;
    logic [2:0] field0;
    logic       shift1, bits_done1, busy1, overrun1;
    logic [3:0] bit_index1;
    logic [2:0] field1;

    uart_frame_sequencer u_dut0 (
        .clock(clock), .reset(reset), .start(start), .tick(tick0), .abort(abort),
        .shift(shift0), .bits_done(bits_done0), .busy(busy0), .overrun(overrun0),
        .bit_index(bit_index0), .field(field0)
    );

    uart_frame_sequencer #(
        .DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2), .OVERSAMPLE(4), .CNT_W(4)
    ) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .tick(tick1), .abort(abort),
        .shift(shift1), .bits_done(bits_done1), .busy(busy1), .overrun(overrun1),
        .bit_index(bit_index1), .field(field1)
    );

    always #5 clock = ~clock;

    logic [10:0] obs0, obs1;
    assign obs0 = {shift0, bits_done0, busy0, overrun0, bit_index0, field0};
    assign obs1 = {shift1, bits_done1, busy1, overrun1, bit_index1, field1};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: phase 0 idle, 1 running, 2 frame just completed
    int          m_ph[2]    = '{0, 0};
    int          m_ticks[2] = '{0, 0};
    logic [10:0] m_exp[2];

    int n_shift0, n_bd0, n_ovr0, n_idle0, first_shift0, bd_cyc0;
    int n_shift1, n_bd1, bd_cyc1, last_shift1, n_f3;
    logic       cap1 = 1'b0;
    logic       prev_busy1 = 1'b0;
    logic [3:0] prev_idx1 = '0;
    logic [2:0] fseq[$];
    logic [2:0] fexp[10] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] slot_field(input int idx, input int db, input int par);
        if (idx == 0) return 3'd1;
        if (idx <= db) return 3'd2;
        if (par != 0 && idx == db + 1) return 3'd3;
        return 3'd4;
    endfunction

    // A frame lasts OS*FB counted ticks; the running tick total gives slot and strobes
    task automatic model(input int d, input logic r, input logic s, input logic t, input logic a);
        int os, fb, db, par, idx;
        logic sh, bd, ov, bz;
        logic [2:0] f;
        os  = (d == 0) ? 16 : 4;
        fb  = (d == 0) ? 11 : 10;
        db  = (d == 0) ? 8 : 7;
        par = (d == 0) ? 1 : 0;
        sh = 1'b0; bd = 1'b0; ov = 1'b0;
        if (r) begin
            m_ph[d] = 0; m_ticks[d] = 0;
        end else if (m_ph[d] == 1) begin
            if (a) begin
                m_ph[d] = 0; m_ticks[d] = 0;
            end else begin
                ov = s;
                if (t) begin
                    m_ticks[d] = m_ticks[d] + 1;
                    if (m_ticks[d] % os == 0) sh = 1'b1;
                    if (m_ticks[d] == os * fb) begin
                        m_ph[d] = 2; bd = 1'b1;
                    end
                end
            end
        end else if (m_ph[d] == 2) begin
            m_ph[d] = (s && !a) ? 1 : 0; m_ticks[d] = 0;
        end else if (s && !a) begin
            m_ph[d] = 1; m_ticks[d] = 0;
        end
        bz  = (m_ph[d] != 0);
        idx = (m_ph[d] == 2) ? fb - 1 : m_ticks[d] / os;
        f   = bz ? slot_field(idx, db, par) : 3'd0;
        m_exp[d] = {sh, bd, bz, ov, 4'(idx), f};
    endtask

    task automatic clr();
        n_shift0 = 0; n_bd0 = 0; n_ovr0 = 0; n_idle0 = 0; first_shift0 = -1; bd_cyc0 = -1;
        n_shift1 = 0; n_bd1 = 0; bd_cyc1 = -1; last_shift1 = -2; n_f3 = 0;
        fseq.delete();
    endtask

    task automatic step(input logic r, input logic s, input logic t0, input logic t1, input logic a);
        reset = r; start = s; tick0 = t0; tick1 = t1; abort = a;
        @(posedge clock);
        #1;
        cyc++;
        model(0, r, s, t0, a);
        model(1, r, s, t1, a);
        chk($sformatf("cyc%0d_dut0", cyc), 32'(obs0), 32'(m_exp[0]));
        chk($sformatf("cyc%0d_dut1", cyc), 32'(obs1), 32'(m_exp[1]));
        if (shift0) begin
            n_shift0++;
            if (first_shift0 < 0) first_shift0 = cyc;
        end
        if (bits_done0) begin n_bd0++; bd_cyc0 = cyc; end
        if (overrun0) n_ovr0++;
        if (!busy0) n_idle0++;
        if (shift1) begin n_shift1++; last_shift1 = cyc; end
        if (bits_done1) begin n_bd1++; bd_cyc1 = cyc; end
        if (field1 == 3'd3) n_f3++;
        if (cap1 && busy1 && (!prev_busy1 || bit_index1 != prev_idx1)) fseq.push_back(field1);
        prev_busy1 = busy1;
        prev_idx1  = bit_index1;
    endtask

    // Default instance sees tick held high, the second one a tick every third cycle
    task automatic go(input logic s, input logic a);
        step(1'b0, s, 1'b1, (cyc % 3) == 0, a);
    endtask

    initial begin
        int s_cyc, k;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_dut0", 32'(obs0), 32'd0);
        chk("reset_dut1", 32'(obs1), 32'd0);
        repeat (6) go(1'b0, 1'b0);

        // Single frame on both instances
        clr(); cap1 = 1'b1;
        go(1'b1, 1'b0); s_cyc = cyc;
        repeat (189) go(1'b0, 1'b0);
        cap1 = 1'b0;
        chk("single_busy_first", 32'(n_idle0), 32'd13);
        chk("single_first_shift", 32'(first_shift0 - s_cyc), 32'd16);
        chk("single_bits_done_cyc", 32'(bd_cyc0 - s_cyc), 32'd176);
        chk("single_shift_cnt", 32'(n_shift0), 32'd11);
        chk("single_bd_cnt", 32'(n_bd0), 32'd1);
        chk("alt_shift_cnt", 32'(n_shift1), 32'd10);
        chk("alt_bd_cnt", 32'(n_bd1), 32'd1);
        chk("alt_bd_with_last_shift", 32'(bd_cyc1), 32'(last_shift1));
        chk("alt_no_parity", 32'(n_f3), 32'd0);
        chk("alt_field_len", 32'(fseq.size()), 32'd10);
        for (int i = 0; i < 10 && i < fseq.size(); i++)
            chk($sformatf("alt_field_%0d", i), 32'(fseq[i]), 32'(fexp[i]));

        // Start during RUN flags overrun but leaves the frame untouched
        clr();
        go(1'b1, 1'b0); s_cyc = cyc;
        k = 0;
        while (bit_index0 != 4'd5 && k < 200) begin go(1'b0, 1'b0); k++; end
        chk("ovr_reach_idx5", 32'(k < 200), 32'd1);
        go(1'b1, 1'b0);
        while (n_bd0 == 0 && k < 400) begin go(1'b0, 1'b0); k++; end
        chk("ovr_count", 32'(n_ovr0), 32'd1);
        chk("ovr_shift_cnt", 32'(n_shift0), 32'd11);
        chk("ovr_bits_done_cyc", 32'(bd_cyc0 - s_cyc), 32'd176);
        repeat (150) go(1'b0, 1'b0);

        // Back-to-back: start only in the DONE cycle of the first frame
        clr();
        go(1'b1, 1'b0); s_cyc = cyc;
        k = 0;
        while (n_bd0 < 2 && k < 500) begin go(bits_done0 && n_bd0 == 1, 1'b0); k++; end
        chk("b2b_bd_cnt", 32'(n_bd0), 32'd2);
        chk("b2b_shift_cnt", 32'(n_shift0), 32'd22);
        chk("b2b_overrun", 32'(n_ovr0), 32'd0);
        chk("b2b_no_gap", 32'(n_idle0), 32'd0);
        chk("b2b_second_done_cyc", 32'(bd_cyc0 - s_cyc), 32'd353);
        go(1'b0, 1'b0);
        chk("b2b_idle_after", 32'(busy0), 32'd0);
        repeat (150) go(1'b0, 1'b0);

        // Abort at bit 4 with nine ticks counted
        go(1'b1, 1'b0);
        k = 0;
        while (bit_index0 != 4'd4 && k < 200) begin go(1'b0, 1'b0); k++; end
        chk("abort_reach_idx4", 32'(k < 200), 32'd1);
        repeat (9) go(1'b0, 1'b0);
        go(1'b0, 1'b1);
        chk("abort_outputs", 32'(obs0), 32'd0);
        clr();
        repeat (40) go(1'b0, 1'b0);
        chk("abort_no_shift", 32'(n_shift0), 32'd0);
        chk("abort_no_bd", 32'(n_bd0), 32'd0);
        clr();
        go(1'b1, 1'b0);
        repeat (190) go(1'b0, 1'b0);
        chk("abort_restart_shift", 32'(n_shift0), 32'd11);
        chk("abort_restart_bd", 32'(n_bd0), 32'd1);

        // Reset mid-frame together with start and abort
        go(1'b1, 1'b0);
        repeat (50) go(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_dut0", 32'(obs0), 32'd0);
        chk("rst_mid_dut1", 32'(obs1), 32'd0);
        clr();
        repeat (30) go(1'b0, 1'b0);
        chk("rst_stays_idle", 32'(n_idle0), 32'd30);
        clr();
        go(1'b1, 1'b0);
        repeat (190) go(1'b0, 1'b0);
        chk("rst_restart_shift", 32'(n_shift0), 32'd11);
        chk("rst_restart_bd", 32'(n_bd0), 32'd1);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, s, a, t0, t1;
            r  = ($urandom_range(0, 999) == 0);
            s  = ($urandom_range(0, 39) == 0);
            a  = ($urandom_range(0, 299) == 0);
            t0 = ($urandom_range(0, 1) == 1);
            t1 = ($urandom_range(0, 2) != 0);
            if (a && (m_ph[0] == 0 || m_ph[1] == 0)) s = 1'b0;
            step(r, s, t0, t1, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_sequencer.md
Name: uart_frame_sequencer

Overview:
- Parametrised successor of the transmitter's fixed 11-bit counter.
- Sequences one UART/IrDA transmit frame: start bit, DATA_BITS data bits, optional parity, 1 or 2 stop bits.
- Each bit is timed by an oversampled baud tick. The block issues shift strobes and a frame-done pulse, and reports the current bit index and field to the shift register and IrDA pulse shaper.
- Adds what the fixed counter lacks: abort, back-to-back frames and start-overrun detection.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_EN, 1, 1 inserts one parity bit slot, 0 omits it.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- OVERSAMPLE, 16, tick pulses per bit period; minimum 1.
- CNT_W, 4, width of bit_index; must hold FRAME_BITS.
- Derived: FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS (11 at defaults).
- Illegal parameter values stop elaboration.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request, sampled each cycle.
- tick  in  1  baud oversample enable, one-cycle pulses.
- abort  in  1  synchronous frame cancel.
- shift  out  1  one-cycle strobe: a bit period completed, advance the shift register.
- bits_done  out  1  one-cycle strobe: final bit of the frame completed.
- busy  out  1  high in RUN and DONE.
- overrun  out  1  one-cycle strobe: start was rejected.
- bit_index  out  CNT_W  current bit slot: 0 is the start bit, FRAME_BITS-1 is the last stop bit.
- field  out  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.

Behaviour:
- Single clock. Reset is synchronous and active-high, port named reset; the clock port is named clock.
- All outputs are registered.
- Reset values: state IDLE, tick_cnt=0, bit_index=0, field=0. shift, bits_done, busy and overrun are all 0.
- Priority every cycle: reset > abort > start > tick.
- IDLE:
  - busy=0, field=0, tick ignored.
  - start=1 gives RUN next cycle with bit_index=0, tick_cnt=0, field=START.
  - abort in IDLE has no effect.
- RUN:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt==OVERSAMPLE-1: tick_cnt returns to 0 and shift=1 in the next cycle.
  - If bit_index<FRAME_BITS-1: bit_index increments in that same next cycle.
  - If bit_index==FRAME_BITS-1: go to DONE instead; shift=1 and bits_done=1 in that same cycle; bit_index holds.
- DONE: lasts exactly one cycle, busy=1.
  - start=1 gives RUN next cycle with counters cleared: gapless back-to-back frame, no overrun.
  - Otherwise go to IDLE.
- field decode from bit_index (RUN and DONE):
  - 0 gives START.
  - 1..DATA_BITS gives DATA.
  - DATA_BITS+1 gives PARITY when PARITY_EN=1.
  - Remaining slots give STOP.
- start in RUN: ignored; frame continues untouched; overrun=1 next cycle, held for one cycle.
- abort in RUN or DONE:
  - Next cycle: IDLE, counters cleared, busy=0.
  - No shift or bits_done for the partial bit.
  - A start in the same cycle is ignored, with no overrun.
- tick arriving in the same cycle as start (from IDLE) is not counted; counting begins the first cycle in RUN.
- Latency, tick held high continuously, OVERSAMPLE=16, start in cycle n:
  - busy=1 at n+1.
  - First shift at n+17.
  - bits_done at n+1+16*FRAME_BITS (n+177 at defaults).
  - IDLE at n+178.
- OVERSAMPLE=1: every tick completes a bit.
- Counter widths are sized so that neither tick_cnt nor bit_index can wrap within a frame.

Test Plan:
- Defaults, tick held high, single start at cycle 10 -> busy=1 from cycle 11; shift at 27, 43, ... 187 (11 pulses); bits_done only at 187; busy=0 at 188.
- DATA_BITS=7, PARITY_EN=0, STOP_BITS=2, OVERSAMPLE=4, tick every 3rd cycle -> 10 shift pulses, bits_done with the 10th; field sequence 1, 2×7, 4, 4; no field 3.
- start pulsed at bit_index=5 during RUN -> overrun one cycle; shift count and bits_done timing identical to an undisturbed frame.
- start held high through DONE -> next frame begins the following cycle with no idle gap; 22 shift pulses and 2 bits_done across two frames; overrun never asserted.
- abort at bit_index=4, tick_cnt=9 -> IDLE next cycle; bit_index=0; no further shift; no bits_done. A new start then produces a full 11-bit frame.
- reset asserted mid-frame together with start and abort -> all outputs at reset values next cycle; the frame restarts only on a later start.
